// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer
//
// Reads 32-bit words from the flash reader one at a time and plays each word
// out as two 16-bit audio samples, one per sample tick. It handles
// play/pause, forward/reverse direction, restart and wrap-around inside the
// sample region [START_ADDR, END_ADDR].
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   sample_tick    one-cycle pulse per audio sample period
//   play           level, 1 = play, 0 = pause
//   dir            level, 0 = forward, 1 = reverse
//   restart        one-cycle pulse: jump to region start (fwd) or end (rev)
//   rd_read        read request to the flash reader (held until rd_valid)
//   rd_address     word address of the current read (always the registered addr)
//   rd_data        word returned by the flash reader
//   rd_valid       one-cycle pulse qualifying rd_data
//   sample         current audio sample
//   sample_strobe  one-cycle pulse when sample updates
//   underrun       one-cycle pulse: a played tick found no buffered sample
//   state_dbg      current FSM state, for observation only
//
// Reader handshake: rd_read rises one cycle after FETCH is entered and stays
// high until rd_valid is sampled high; it drops on the following edge.
// Exactly one rd_valid is expected per request; rd_valid outside WAIT_DATA
// is ignored.
module flash_audio_sequencer #(
  parameter int              ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              dir,
  input  logic              restart,
  output logic              rd_read,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [31:0]       rd_data,
  input  logic              rd_valid,
  output logic [15:0]       sample,
  output logic              sample_strobe,
  output logic              underrun,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    FETCH       = 2'd0,
    WAIT_DATA   = 2'd1,
    FIRST_HALF  = 2'd2,
    SECOND_HALF = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [31:0]       word_buf, word_buf_n;
  logic              word_dir, word_dir_n;
  logic              discard, discard_n;
  logic              rd_read_n;
  logic [15:0]       sample_n;
  logic              strobe_n;
  logic              underrun_n;

  logic              tick_play;
  logic [ADDR_W-1:0] restart_addr;
  logic [ADDR_W-1:0] advance_addr;
  logic [15:0]       first_half;
  logic [15:0]       second_half;

  // restart takes priority over a tick in the same cycle
  assign tick_play    = sample_tick & play & ~restart;
  assign restart_addr = dir ? END_ADDR : START_ADDR;

  // The advance uses the live dir, not the direction the word was captured with.
  always_comb begin
    advance_addr = addr;
    if (dir) advance_addr = (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
    else     advance_addr = (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
  end

  // A word captured in reverse plays its high half first, so reverse
  // playback is the exact mirror of forward playback.
  assign first_half  = word_dir ? word_buf[31:16] : word_buf[15:0];
  assign second_half = word_dir ? word_buf[15:0]  : word_buf[31:16];

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    word_buf_n = word_buf;
    word_dir_n = word_dir;
    discard_n  = discard;
    rd_read_n  = rd_read;
    sample_n   = sample;
    strobe_n   = 1'b0;
    underrun_n = 1'b0;

    case (state)
      FETCH: begin
        if (restart) begin
          addr_n = restart_addr;
        end else begin
          rd_read_n = 1'b1;
          state_n   = WAIT_DATA;
        end
        if (tick_play) underrun_n = 1'b1;
      end

      WAIT_DATA: begin
        if (restart) addr_n = restart_addr;
        if (rd_valid) begin
          rd_read_n = 1'b0;
          if (discard || restart) begin
            // stale data for an abandoned address: re-read at the new addr
            discard_n = 1'b0;
            state_n   = FETCH;
          end else begin
            word_buf_n = rd_data;
            word_dir_n = dir;
            state_n    = FIRST_HALF;
          end
        end else if (restart) begin
          // the read in flight must still complete before a new one is issued
          discard_n = 1'b1;
        end
        if (tick_play) underrun_n = 1'b1;
      end

      FIRST_HALF: begin
        if (restart) begin
          addr_n  = restart_addr;
          state_n = FETCH;
        end else if (tick_play) begin
          sample_n = first_half;
          strobe_n = 1'b1;
          state_n  = SECOND_HALF;
        end
      end

      SECOND_HALF: begin
        if (restart) begin
          addr_n  = restart_addr;
          state_n = FETCH;
        end else if (tick_play) begin
          sample_n = second_half;
          strobe_n = 1'b1;
          addr_n   = advance_addr;
          state_n  = FETCH;
        end
      end

      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      addr          <= START_ADDR;
      word_buf      <= '0;
      word_dir      <= 1'b0;
      discard       <= 1'b0;
      rd_read       <= 1'b0;
      sample        <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      word_buf      <= word_buf_n;
      word_dir      <= word_dir_n;
      discard       <= discard_n;
      rd_read       <= rd_read_n;
      sample        <= sample_n;
      sample_strobe <= strobe_n;
      underrun      <= underrun_n;
    end
  end

  assign rd_address = addr;
  assign state_dbg  = state;

endmodule

// File: doc/flash_audio_sequencer.md
Name: flash_audio_sequencer

Overview:
- Sequences 32-bit reads from the flash memory reader: issues read requests, buffers one word, and plays it out as two 16-bit audio samples, one per sample tick.
- Sits between the flash reader and the audio output path.
- Handles play/pause, forward/reverse direction, restart and address wrap-around so the top level contains no flash-sequencing logic.

Parameters:
ADDR_W, 23, word-address width driven to the flash reader
START_ADDR, 23'h0, first word address of the sample region
END_ADDR, 23'h7FFFF, last word address of the sample region (inclusive)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sample_tick  input  1  one-cycle pulse, one per audio sample period
play  input  1  level: 1 = play, 0 = pause
dir  input  1  level: 0 = forward, 1 = reverse
restart  input  1  one-cycle pulse: jump to region start (forward) or end (reverse)
rd_read  output  1  read request to flash reader
rd_address  output  ADDR_W  word address for the current read
rd_data  input  32  word returned by flash reader
rd_valid  input  1  one-cycle pulse: rd_data is valid
sample  output  16  current audio sample
sample_strobe  output  1  one-cycle pulse when sample updates
underrun  output  1  one-cycle pulse: tick arrived with no buffered sample

Behaviour:
- Reset values:
  - state FETCH; addr = START_ADDR.
  - rd_read = 0, sample = 16'h0, sample_strobe = 0, underrun = 0.
  - Buffer empty; discard flag = 0.
- Reset is honoured in any state, including mid-read. The reader is reset by the same rst.
- rd_address is always the registered addr.
- States: FETCH, WAIT_DATA, FIRST_HALF, SECOND_HALF.
- FETCH:
  - rd_read is registered high one cycle after entry; go to WAIT_DATA.
  - Prefetch happens regardless of play.
- WAIT_DATA:
  - Hold rd_read = 1 until rd_valid is sampled high; rd_read = 0 on the next edge.
  - On rd_valid with discard = 0: capture rd_data into buf, latch word_dir = dir, go to FIRST_HALF.
  - On rd_valid with discard = 1: drop the data, clear discard, go to FETCH (re-reads at the updated addr).
- Half selection:
  - word_dir = 0: first half = buf[15:0], second half = buf[31:16].
  - word_dir = 1: first half = buf[31:16], second half = buf[15:0].
  - Reverse playback is therefore sample-exact.
- FIRST_HALF: on sample_tick & play, register sample = first half, pulse sample_strobe, go to SECOND_HALF.
- SECOND_HALF: on sample_tick & play, register sample = second half, pulse sample_strobe, advance addr, go to FETCH.
- Output latency: sample and sample_strobe change on the edge following the tick (1-cycle latency).
- Address advance:
  - dir sampled at the advance, not word_dir.
  - Forward: addr+1; END_ADDR wraps to START_ADDR.
  - Reverse: addr-1; START_ADDR wraps to END_ADDR.
- Pause (play = 0):
  - Ticks are ignored, with no strobe and no underrun.
  - State, buf and sample are held.
  - An outstanding fetch still completes into buf.
- Underrun: sample_tick & play while in FETCH or WAIT_DATA pulses underrun the next cycle; sample is held and no strobe is generated.
- restart:
  - addr = START_ADDR if dir = 0, else END_ADDR; buffer discarded.
  - In FIRST_HALF or SECOND_HALF: go to FETCH.
  - In FETCH: stay in FETCH with the new addr.
  - In WAIT_DATA: set discard = 1 and stay; the outstanding read completes (rd_read still held until rd_valid) and is dropped.
  - restart with sample_tick in the same cycle: restart wins; the tick is ignored, with no strobe and no underrun.
- A dir change mid-word affects only the next address advance and the next captured word.
- Reader protocol assumed:
  - rd_valid arrives only while rd_read is high.
  - Exactly one rd_valid arrives per request.
  - Stray rd_valid in other states is ignored.

Test Plan:
- Forward play: flash model word[0] = 32'hBBBB_AAAA, word[1] = 32'hDDDD_CCCC, dir = 0, play = 1, ticks every 20 cycles -> strobes with sample AAAA, BBBB, CCCC, DDDD; rd_address 0, 1, 2; no underrun.
- Reverse and wrap: START_ADDR = 0, END_ADDR = 3, dir = 1, restart -> first read at addr 3. word[3] = 32'h4444_3333 -> samples 4444 then 3333; addresses go 3, 2, 1, 0, 3.
- Forward wrap: END_ADDR = 3, dir = 0, play through 8 ticks -> rd_address sequence 0, 1, 2, 3, 0; samples repeat from word[0] low half.
- Underrun/pause: flash latency 30 cycles, tick every 5 cycles -> underrun pulses in WAIT_DATA with sample held. Then play = 0 for 10 ticks -> no strobe, no underrun, and sample/addr unchanged.
- Restart mid-read: restart asserted while rd_read is high at addr 2 -> the outstanding rd_valid data is not played; the next read is at START_ADDR; the next strobe carries word[START_ADDR] low half.
- Reset mid-operation: rst in SECOND_HALF -> the next cycle has sample = 0, rd_read = 0 and no strobe; rd_read goes high one cycle after rst deasserts, with rd_address = START_ADDR.
